// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Vi pipeline memory-access stage: req/ack data-memory port and registered writeback record
// Optional bus timeout on a stuck request: define MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        bus_err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    logic [1:0]  r_state, w_next;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_wb_valid, r_wb_we, r_misal, r_illegal;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic        w_is_load, w_is_store, w_is_mem, w_legal, w_misal;
    logic        w_accepting, w_start, w_timeout, w_unused;
    logic [31:0] w_st_wdata, w_load_data;
    logic [3:0]  w_st_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_opcode    = instr_i[6:0];
    assign w_rd        = instr_i[11:7];
    assign w_f3        = instr_i[14:12];
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_mem    = w_is_load || w_is_store;
    assign w_legal     = w_is_load ? ((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                                      (w_f3 == 3'b100) || (w_f3 == 3'b101))
                                   : (!w_f3[2] && (w_f3[1:0] != 2'b11));
    assign w_misal     = ((w_f3[1:0] == 2'b01) && alu_result_i[0]) ||
                         ((w_f3[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_RESP);
    assign w_start     = w_accepting && valid_i && w_is_mem && w_legal && !w_misal;

    assign stall_o      = !rsn_i && ((r_state == S_REQ) || w_start);
    assign mem_req_o    = (r_state == S_REQ);
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_be_o     = r_be;
    assign wb_valid_o   = r_wb_valid;
    assign wb_we_o      = r_wb_we;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign misaligned_o = r_misal;
    assign illegal_o    = r_illegal;

    always_comb begin
        w_st_wdata = store_data_i;
        w_st_be    = 4'b1111;
        case (w_f3[1:0])
            2'b00: begin
                w_st_wdata = {4{store_data_i[7:0]}};
                w_st_be    = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{store_data_i[15:0]}};
                w_st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata_i[7:0];
            2'd1:    w_byte = mem_rdata_i[15:8];
            2'd2:    w_byte = mem_rdata_i[23:16];
            default: w_byte = mem_rdata_i[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = mem_rdata_i;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_bus_err;

    // Ack in the final allowed cycle still completes the access normally.
    assign w_timeout = (r_state == S_REQ) && !mem_ack_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = r_bus_err;
    assign w_unused  = ^instr_i[31:15];

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start)
                r_cnt <= '0;
            else if (r_state == S_REQ)
                r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err_o = 1'b0;
    assign w_unused  = ^instr_i[31:15] ^ (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   if (mem_ack_i || w_timeout) w_next = S_RESP;
            default: w_next = w_start ? S_REQ : S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_off      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_misal    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr  <= {alu_result_i[31:2], 2'b00};
                r_we    <= w_is_store;
                r_be    <= w_is_store ? w_st_be : 4'b0000;
                r_wdata <= w_is_store ? w_st_wdata : 32'b0;
                r_rd    <= w_rd;
                r_f3    <= w_f3;
                r_off   <= alu_result_i[1:0];
            end
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_misal    <= 1'b0;
            r_illegal  <= 1'b0;
            if (r_state == S_REQ) begin
                if (mem_ack_i) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_we    <= !r_we && (r_rd != 5'd0);
                    r_wb_data  <= r_we ? 32'b0 : w_load_data;
                end else if (w_timeout) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= 32'b0;
                end
            end else if (w_accepting && valid_i) begin
                r_wb_rd <= w_rd;
                if (!w_is_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= alu_result_i;
                    r_wb_we    <= ((w_opcode == OP_REG) || (w_opcode == OP_IMM)) && (w_rd != 5'd0);
                end else if (!w_legal) begin
                    r_wb_valid <= 1'b1;
                    r_illegal  <= 1'b1;
                end else if (w_misal) begin
                    r_wb_valid <= 1'b1;
                    r_misal    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rsn_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = '0, alu_result_i = '0, store_data_i = '0;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        wb_valid_o, wb_we_o, misaligned_o, illegal_o, bus_err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        ill;
        logic        berr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int          ack_delay = 0;
    logic [31:0] rd_word = '0;
    int          req_cnt = 0;
    bit          force_ack = 1'b0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rsn_i(rsn_i), .valid_i(valid_i), .instr_i(instr_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .misaligned_o(misaligned_o),
        .illegal_o(illegal_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    // Memory responder: acks on the (ack_delay)-th cycle of a request.
    always @(negedge clk) begin
        if (mem_req_o) begin
            mem_ack_i   = (req_cnt == ack_delay);
            mem_rdata_i = mem_ack_i ? rd_word : 32'hDEAD_BEEF;
            req_cnt++;
        end else begin
            mem_ack_i   = force_ack;
            mem_rdata_i = 32'hDEAD_BEEF;
            req_cnt     = 0;
        end
    end

    always @(negedge clk) begin
        if (!rsn_i && wb_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h we=%0b, required no record",
                         wb_rd_o, wb_data_o, wb_we_o);
            end else begin
                mon_e = sb.pop_front();
                if (wb_we_o !== mon_e.we || misaligned_o !== mon_e.mis || illegal_o !== mon_e.ill ||
                    bus_err_o !== mon_e.berr ||
                    (mon_e.we && (wb_rd_o !== mon_e.rd || wb_data_o !== mon_e.data))) begin
                    errors++;
                    $display("FAIL wb_record: got we=%0b rd=%0d data=%h mis=%0b ill=%0b berr=%0b, required we=%0b rd=%0d data=%h mis=%0b ill=%0b berr=%0b",
                             wb_we_o, wb_rd_o, wb_data_o, misaligned_o, illegal_o, bus_err_o,
                             mon_e.we, mon_e.rd, mon_e.data, mon_e.mis, mon_e.ill, mon_e.berr);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {17'b0, f3, rd, op};
    endfunction

    function automatic exp_t ex(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input logic mis, input logic ill, input logic berr);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.mis = mis; e.ill = ill; e.berr = berr;
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] s);
        valid_i = 1'b1; instr_i = ins; alu_result_i = a; store_data_i = s;
    endtask

    task automatic observe(input int n, output int n_stall, output int n_req, output logic [31:0] a,
                           output logic [31:0] wd, output logic [3:0] be, output logic we);
        n_stall = 0; n_req = 0; a = '0; wd = '0; be = '0; we = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall_o) n_stall++;
            if (mem_req_o) begin
                n_req++; a = mem_addr_o; wd = mem_wdata_o; be = mem_be_o; we = mem_we_o;
            end
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !stall_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall_o, mem_req_o, mem_we_o, wb_valid_o, wb_we_o, misaligned_o, illegal_o, bus_err_o} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {stall_o, mem_req_o, mem_we_o, wb_valid_o, wb_we_o, misaligned_o, illegal_o, bus_err_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, mem_be_o, wb_rd_o, wb_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h be=%b rd=%0d data=%h, required all 0",
                     mem_addr_o, mem_wdata_o, mem_be_o, wb_rd_o, wb_data_o);
        end
        @(posedge clk); #1;
        rsn_i = 1'b0;
    endtask

    task automatic test_alu;
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we; bit ok;
        sb.push_back(ex(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b0));
        drive(mk(7'b0110011, 5'd5, 3'b000), 32'h0000_1234, 32'h0);
        observe(2, ns, nr, a, wd, be, we);
        checks++;
        if (ns != 0 || nr != 0) begin
            errors++; $display("FAIL alu_add_stall: got stall=%0d req=%0d, required 0 0", ns, nr);
        end
        sb.push_back(ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
        drive(mk(7'b0010011, 5'd0, 3'b000), 32'h0000_0077, 32'h0);
        observe(1, ns, nr, a, wd, be, we);
        sb.push_back(ex(1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 1'b0));
        drive(mk(7'b0110111, 5'd7, 3'b000), 32'hABCD_0000, 32'h0);
        observe(1, ns, nr, a, wd, be, we);
        sb.push_back(ex(1'b1, 5'd31, 32'hFFFF_0001, 1'b0, 1'b0, 1'b0));
        drive(mk(7'b0010011, 5'd31, 3'b110), 32'hFFFF_0001, 32'h0);
        observe(3, ns, nr, a, wd, be, we);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL alu_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_load_lb;
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we; bit ok;
        ack_delay = 1; rd_word = 32'h0080_0000;
        sb.push_back(ex(1'b1, 5'd3, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0));
        drive(mk(7'b0000011, 5'd3, 3'b000), 32'h0000_1002, 32'h0);
        observe(6, ns, nr, a, wd, be, we);
        checks++;
        if (ns != 3 || nr != 2) begin
            errors++; $display("FAIL lb_stall: got stall=%0d req=%0d, required 3 2", ns, nr);
        end
        checks++;
        if (a !== 32'h0000_1000 || be !== 4'b0000 || we !== 1'b0) begin
            errors++; $display("FAIL lb_bus: got addr=%h be=%b we=%0b, required 00001000 0000 0", a, be, we);
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lb_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_load_lanes;
        logic [2:0]  f3[8]   = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b101, 3'b000};
        logic [31:0] adr[8]  = '{32'h40, 32'h41, 32'h43, 32'h42, 32'h40, 32'h44, 32'h42, 32'h42};
        logic [4:0]  rdn[8]  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd0};
        logic [31:0] exd[8]  = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_FF80, 32'hFFFF_80F1,
                                 32'h0000_7F82, 32'h80F1_7F82, 32'h0000_80F1, 32'hFFFF_FFF1};
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we;
        ack_delay = 0; rd_word = 32'h80F1_7F82;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ex(rdn[i] != 5'd0, rdn[i], exd[i], 1'b0, 1'b0, 1'b0));
            drive(mk(7'b0000011, rdn[i], f3[i]), adr[i], 32'h0);
            observe(4, ns, nr, a, wd, be, we);
            checks++;
            if (nr != 1 || a !== {adr[i][31:2], 2'b00} || ns != 2) begin
                errors++;
                $display("FAIL load_lane%0d: got req=%0d stall=%0d addr=%h, required 1 2 %h",
                         i, nr, ns, a, {adr[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_store;
        logic [2:0]  f3[5]  = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b010};
        logic [31:0] adr[5] = '{32'h2002, 32'h101, 32'h103, 32'h200, 32'h304};
        logic [31:0] dat[5] = '{32'hABCD_1234, 32'h1234_56A5, 32'h0000_005A, 32'hFFFF_BEEF, 32'h0102_0304};
        logic [31:0] exw[5] = '{32'h1234_1234, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hBEEF_BEEF, 32'h0102_0304};
        logic [3:0]  exb[5] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111};
        logic [31:0] exa[5] = '{32'h2000, 32'h100, 32'h100, 32'h200, 32'h304};
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we;
        ack_delay = 0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex(1'b0, 5'd9, 32'h0, 1'b0, 1'b0, 1'b0));
            drive(mk(7'b0100011, 5'd9, f3[i]), adr[i], dat[i]);
            observe(4, ns, nr, a, wd, be, we);
            checks++;
            if (nr != 1 || we !== 1'b1 || a !== exa[i] || be !== exb[i] || wd !== exw[i]) begin
                errors++;
                $display("FAIL store%0d: got req=%0d we=%0b addr=%h be=%b wdata=%h, required 1 1 %h %b %h",
                         i, nr, we, a, be, wd, exa[i], exb[i], exw[i]);
            end
        end
    endtask

    task automatic test_misaligned_illegal;
        logic [6:0]  op[5]  = '{7'b0000011, 7'b0000011, 7'b0100011, 7'b0000011, 7'b0100011};
        logic [2:0]  f3[5]  = '{3'b010, 3'b101, 3'b001, 3'b011, 3'b100};
        logic [31:0] adr[5] = '{32'h3001, 32'h3003, 32'h3005, 32'h3001, 32'h3000};
        logic        emi[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex(1'b0, 5'd6, 32'h0, emi[i], !emi[i], 1'b0));
            drive(mk(op[i], 5'd6, f3[i]), adr[i], 32'h0);
            observe(3, ns, nr, a, wd, be, we);
            checks++;
            if (nr != 0 || ns != 0) begin
                errors++; $display("FAIL bad_access%0d: got req=%0d stall=%0d, required 0 0", i, nr, ns);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        ack_delay = 0; rd_word = 32'h0000_00F0;
        sb.push_back(ex(1'b1, 5'd4, 32'h0000_00F0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0));
        drive(mk(7'b0000011, 5'd4, 3'b100), 32'h0000_0010, 32'h0);
        @(posedge clk); #1; valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin
            errors++; $display("FAIL b2b_first_req: got req=%0b addr=%h we=%0b, required 1 00000010 0",
                               mem_req_o, mem_addr_o, mem_we_o);
        end
        @(posedge clk); #1;
        drive(mk(7'b0100011, 5'd0, 3'b010), 32'h0000_0020, 32'hCAFE_F00D);
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++; $display("FAIL b2b_resp: got req=%0b stall=%0b, required 0 1", mem_req_o, stall_o);
        end
        @(posedge clk); #1; valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h20 ||
            mem_be_o !== 4'b1111 || mem_wdata_o !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_second_req: got req=%0b we=%0b addr=%h be=%b wdata=%h, required 1 1 00000020 1111 cafef00d",
                               mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_stray_ack;
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we;
        force_ack = 1'b1;
        observe(3, ns, nr, a, wd, be, we);
        force_ack = 1'b0;
        checks++;
        if (nr != 0 || ns != 0) begin
            errors++; $display("FAIL stray_ack: got req=%0d stall=%0d, required 0 0", nr, ns);
        end
    endtask

    task automatic test_reset_in_req;
        ack_delay = 1000;
        drive(mk(7'b0000011, 5'd9, 3'b010), 32'h0000_0040, 32'h0);
        @(posedge clk); #1; valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rst_req_pre: got req=%0b, required 1", mem_req_o);
        end
        #2 rsn_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rst_abort: got req=%0b stall=%0b addr=%h, required 0 0 00000000",
                               mem_req_o, stall_o, mem_addr_o);
        end
        @(posedge clk); #1; rsn_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_after: got req=%0b wb_valid=%0b, required 0 0", mem_req_o, wb_valid_o);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int ns, nr; logic [31:0] a, wd; logic [3:0] be; logic we; bit ok;
        ack_delay = 1000;
        sb.push_back(ex(1'b0, 5'd8, 32'h0, 1'b0, 1'b0, 1'b1));
        drive(mk(7'b0000011, 5'd8, 3'b010), 32'h0000_0050, 32'h0);
        observe(8, ns, nr, a, wd, be, we);
        checks++;
        if (nr != 4 || ns != 5) begin
            errors++; $display("FAIL timeout_len: got req=%0d stall=%0d, required 4 5", nr, ns);
        end
        ack_delay = 3;
        sb.push_back(ex(1'b1, 5'd8, 32'h1111_2222, 1'b0, 1'b0, 1'b0));
        rd_word = 32'h1111_2222;
        drive(mk(7'b0000011, 5'd8, 3'b010), 32'h0000_0054, 32'h0);
        observe(8, ns, nr, a, wd, be, we);
        checks++;
        if (nr != 4) begin
            errors++; $display("FAIL timeout_ack_wins: got req=%0d, required 4", nr);
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_drain: got %0d pending, required 0", sb.size()); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_alu;
        test_load_lb;
        test_load_lanes;
        test_store;
        test_misaligned_illegal;
        test_back_to_back;
        test_stray_ack;
        test_reset_in_req;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`endif
        repeat (4) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
